// File: rtl/led_pwm_engine.sv
// -----------------------------------------------------------------------------
// led_pwm_engine
//
// Multi-channel LED output engine. Every channel has its own PWM duty and a
// mode (off / on / pwm / blink). Duty and mode writes land in a shadow set and
// are promoted to the active set only at a PWM period boundary, so a running
// waveform is never cut short or stretched by a register write.
//
// A programmable prescaler generates the PWM tick. The PWM period is
// 2^R-1 ticks (cnt runs 0..2^R-2), which lets duty 0 mean "never on" and
// duty 2^R-1 mean "always on" without any special casing.
//
// Ports
//   clk          clock
//   rst_n        synchronous, active-low reset
//   enable       global run enable; 0 parks counters and drives LEDs inactive
//   prescale     tick every prescale+1 clocks
//   blink_half   blink half-period = blink_half+1 PWM periods
//   duty_in      packed duties, channel i = duty_in[i*R +: R]
//   mode_in      packed modes,  channel i = mode_in[2i +: 2]
//                00 off, 01 on, 10 pwm, 11 blink
//   update_req   1-cycle pulse, captures duty_in/mode_in into the shadow set
//   update_ack   1-cycle pulse, shadow set has been copied to the active set
//   period_tick  1-cycle pulse marking the last tick of each PWM period
//   LED          registered LED pins, inverted when ACTIVE_LOW=1
// -----------------------------------------------------------------------------
module led_pwm_engine #(
    parameter int NUM_LEDS       = 4,
    parameter int PWM_RESOLUTION = 8,
    parameter int PRESCALE_WIDTH = 16,
    parameter int BLINK_WIDTH    = 8,
    parameter bit ACTIVE_LOW     = 1'b0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               enable,
    input  logic [PRESCALE_WIDTH-1:0]          prescale,
    input  logic [BLINK_WIDTH-1:0]             blink_half,
    input  logic [NUM_LEDS*PWM_RESOLUTION-1:0] duty_in,
    input  logic [2*NUM_LEDS-1:0]              mode_in,
    input  logic                               update_req,
    output logic                               update_ack,
    output logic                               period_tick,
    output logic [NUM_LEDS-1:0]                LED
);

    localparam int R  = PWM_RESOLUTION;
    localparam int PW = PRESCALE_WIDTH;
    localparam int BW = BLINK_WIDTH;
    localparam int DW = NUM_LEDS * PWM_RESOLUTION;
    localparam int MW = 2 * NUM_LEDS;

    // Last counter value of a period: 2^R-2, i.e. all ones except the LSB.
    localparam logic [R-1:0]  CNT_LAST  = {{(R-1){1'b1}}, 1'b0};
    localparam logic [R-1:0]  CNT_ZERO  = {R{1'b0}};
    localparam logic [R-1:0]  CNT_ONE   = {{(R-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PCNT_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PCNT_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [BW-1:0] BCNT_ZERO = {BW{1'b0}};
    localparam logic [BW-1:0] BCNT_ONE  = {{(BW-1){1'b0}}, 1'b1};
    localparam logic [NUM_LEDS-1:0] LED_INACTIVE = {NUM_LEDS{ACTIVE_LOW}};

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_PWM   = 2'b10;
    localparam logic [1:0] MODE_BLINK = 2'b11;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PW-1:0]       pcnt_r;
    logic [R-1:0]        cnt_r;
    logic [BW-1:0]       bcnt_r;
    logic                blink_phase_r;

    logic [DW-1:0]       duty_act_r;
    logic [MW-1:0]       mode_act_r;
    logic [DW-1:0]       duty_shd_r;
    logic [MW-1:0]       mode_shd_r;
    logic                pending_r;

    // -------------------------------------------------------------------------
    // Combinational decode
    // -------------------------------------------------------------------------
    logic                tick_s;
    logic                period_end_s;
    logic                blink_wrap_s;
    logic                apply_s;
    logic [NUM_LEDS-1:0] raw_s;

    // Per-channel level before polarity: selects the source by mode.
    function automatic logic chan_level(input logic [1:0] mode,
                                        input logic       pwm_on,
                                        input logic       phase);
        logic level;
        case (mode)
            MODE_OFF:   level = 1'b0;
            MODE_ON:    level = 1'b1;
            MODE_PWM:   level = pwm_on;
            MODE_BLINK: level = pwm_on & phase;
            default:    level = 1'b0;
        endcase
        return level;
    endfunction

    // Prescaler tick. Using >= makes a lowered prescale take effect at once
    // when the running count is already past the new terminal value.
    always_comb begin
        tick_s = 1'b0;
        if (enable && (pcnt_r >= prescale)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    // Period boundary: the tick that moves cnt from its last value back to 0.
    always_comb begin
        period_end_s = 1'b0;
        if (tick_s && (cnt_r == CNT_LAST)) begin
            period_end_s = 1'b1;
        end else begin
            period_end_s = 1'b0;
        end
    end

    // Blink counter terminal; >= keeps a shrunken blink_half from overrunning.
    always_comb begin
        blink_wrap_s = 1'b0;
        if (bcnt_r >= blink_half) begin
            blink_wrap_s = 1'b1;
        end else begin
            blink_wrap_s = 1'b0;
        end
    end

    // Promote shadow to active at a period boundary, or straight away while
    // disabled. A request in the same cycle wins and defers the promotion,
    // so the freshly captured value is the one that eventually goes live.
    always_comb begin
        apply_s = 1'b0;
        if (pending_r && !update_req && (period_end_s || !enable)) begin
            apply_s = 1'b1;
        end else begin
            apply_s = 1'b0;
        end
    end

    // Raw channel levels from the active duty/mode set and the current count.
    always_comb begin
        raw_s = {NUM_LEDS{1'b0}};
        for (int i = 0; i < NUM_LEDS; i++) begin
            raw_s[i] = chan_level(mode_act_r[2*i +: 2],
                                  (cnt_r < duty_act_r[i*R +: R]),
                                  blink_phase_r);
        end
    end

    // -------------------------------------------------------------------------
    // Sequential logic
    // -------------------------------------------------------------------------

    // Prescaler: counts 0..prescale, parked at 0 while disabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt_r <= PCNT_ZERO;
        end else if (!enable) begin
            pcnt_r <= PCNT_ZERO;
        end else if (tick_s) begin
            pcnt_r <= PCNT_ZERO;
        end else begin
            pcnt_r <= pcnt_r + PCNT_ONE;
        end
    end

    // PWM counter: advances on tick over 0..2^R-2, parked at 0 while disabled
    // so re-enabling always starts a fresh period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else if (!enable) begin
            cnt_r <= CNT_ZERO;
        end else if (tick_s) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r <= CNT_ZERO;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    // Blink timebase: counts PWM periods and toggles the phase at each wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcnt_r        <= BCNT_ZERO;
            blink_phase_r <= 1'b1;
        end else if (!enable) begin
            bcnt_r        <= BCNT_ZERO;
            blink_phase_r <= 1'b1;
        end else if (period_end_s) begin
            if (blink_wrap_s) begin
                bcnt_r        <= BCNT_ZERO;
                blink_phase_r <= ~blink_phase_r;
            end else begin
                bcnt_r <= bcnt_r + BCNT_ONE;
            end
        end
    end

    // Double-buffered configuration and the update handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty_shd_r <= {DW{1'b0}};
            mode_shd_r <= {MW{1'b0}};
            duty_act_r <= {DW{1'b0}};
            mode_act_r <= {MW{1'b0}};
            pending_r  <= 1'b0;
            update_ack <= 1'b0;
        end else begin
            update_ack <= apply_s;
            if (update_req) begin
                duty_shd_r <= duty_in;
                mode_shd_r <= mode_in;
                pending_r  <= 1'b1;
            end else if (apply_s) begin
                duty_act_r <= duty_shd_r;
                mode_act_r <= mode_shd_r;
                pending_r  <= 1'b0;
            end
        end
    end

    // Registered pins and period marker; pins fall to the inactive level
    // one clock after enable drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_tick <= 1'b0;
            LED         <= LED_INACTIVE;
        end else if (!enable) begin
            period_tick <= 1'b0;
            LED         <= LED_INACTIVE;
        end else begin
            period_tick <= period_end_s;
            LED         <= raw_s ^ LED_INACTIVE;
        end
    end

endmodule

// File: tb/tb_led_pwm_engine.sv
// -----------------------------------------------------------------------------
// tb_led_pwm_engine
//
// Directed bench for led_pwm_engine. Two instances share all inputs: one with
// active-high pins and one with ACTIVE_LOW=1. Inputs change #1 after the
// rising edge; outputs are sampled at the same point, i.e. they reflect the
// edge just taken. Edge numbering in comments: E1 is the first edge with
// enable=1, and before edge Ek the PWM counter holds k-1 (prescale=0).
// -----------------------------------------------------------------------------
module tb_led_pwm_engine;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [15:0] prescale;
    logic [7:0]  blink_half;
    logic [31:0] duty_in;
    logic [7:0]  mode_in;
    logic        update_req;

    logic        update_ack;
    logic        period_tick;
    logic [3:0]  led;
    logic        update_ack_al;
    logic        period_tick_al;
    logic [3:0]  led_al;

    int total  = 0;
    int passed = 0;

    led_pwm_engine #(
        .NUM_LEDS(4), .PWM_RESOLUTION(8), .PRESCALE_WIDTH(16),
        .BLINK_WIDTH(8), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .prescale(prescale),
        .blink_half(blink_half), .duty_in(duty_in), .mode_in(mode_in),
        .update_req(update_req), .update_ack(update_ack),
        .period_tick(period_tick), .LED(led)
    );

    led_pwm_engine #(
        .NUM_LEDS(4), .PWM_RESOLUTION(8), .PRESCALE_WIDTH(16),
        .BLINK_WIDTH(8), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .rst_n(rst_n), .enable(enable), .prescale(prescale),
        .blink_half(blink_half), .duty_in(duty_in), .mode_in(mode_in),
        .update_req(update_req), .update_ack(update_ack_al),
        .period_tick(period_tick_al), .LED(led_al)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load a configuration while disabled: request on one edge, applied on the next.
    task automatic load(input logic [31:0] d, input logic [7:0] m);
        enable = 1'b0;
        step();
        duty_in    = d;
        mode_in    = m;
        update_req = 1'b1;
        step();
        update_req = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; prescale = 16'd0; blink_half = 8'd0;
        duty_in = 32'd0; mode_in = 8'd0; update_req = 1'b0;
        step(); step();
        total++; if (led !== 4'b0000) $display("FAIL reset_led: got %b expected %b", led, 4'b0000); else passed++;
        total++; if (led_al !== 4'b1111) $display("FAIL reset_led_al: got %b expected %b", led_al, 4'b1111); else passed++;
        total++; if (update_ack !== 1'b0) $display("FAIL reset_ack: got %b expected 0", update_ack); else passed++;
        total++; if (period_tick !== 1'b0) $display("FAIL reset_tick: got %b expected 0", period_tick); else passed++;
        rst_n = 1'b1;
        step();
    endtask

    // T1: duty 64 at prescale 0 -> 64 high clocks of every 255, tick on the last.
    task automatic test_pwm_duty64();
        int hi, tk, tkpos, others;
        prescale = 16'd0; blink_half = 8'd0;
        load({24'd0, 8'd64}, 8'b0000_0010);
        total++; if (update_ack !== 1'b1) $display("FAIL t1_load_ack: got %b expected 1", update_ack); else passed++;
        enable = 1'b1;
        others = 0;
        for (int p = 0; p < 3; p++) begin
            hi = 0; tk = 0; tkpos = -1;
            for (int j = 0; j < 255; j++) begin
                step();
                if (led[0] === 1'b1) hi++;
                if (period_tick === 1'b1) begin tk++; tkpos = j; end
                if (led[3:1] !== 3'b000) others++;
            end
            total++; if (hi !== 64) $display("FAIL t1_high p%0d: got %0d expected 64", p, hi); else passed++;
            total++; if (tk !== 1) $display("FAIL t1_ticks p%0d: got %0d expected 1", p, tk); else passed++;
            total++; if (tkpos !== 254) $display("FAIL t1_tickpos p%0d: got %0d expected 254", p, tkpos); else passed++;
        end
        total++; if (others !== 0) $display("FAIL t1_off_channels: got %0d expected 0", others); else passed++;
    endtask

    // T2: duty 0 (ch0) and duty 255 (ch1), prescale 3 -> constant levels over 3 periods.
    task automatic test_duty_extremes();
        int bad0, bad1, tk, last;
        prescale = 16'd3;
        load({8'd0, 8'd0, 8'd255, 8'd0}, 8'b0000_1010);
        enable = 1'b1;
        bad0 = 0; bad1 = 0; tk = 0; last = -1;
        for (int j = 0; j < 3060; j++) begin
            step();
            if (led[0] !== 1'b0) bad0++;
            if (led[1] !== 1'b1) bad1++;
            if (period_tick === 1'b1) begin tk++; last = j; end
        end
        total++; if (bad0 !== 0) $display("FAIL t2_duty0: got %0d high samples expected 0", bad0); else passed++;
        total++; if (bad1 !== 0) $display("FAIL t2_duty255: got %0d low samples expected 0", bad1); else passed++;
        total++; if (tk !== 3) $display("FAIL t2_ticks: got %0d expected 3", tk); else passed++;
        total++; if (last !== 3059) $display("FAIL t2_lasttick: got %0d expected 3059", last); else passed++;
    endtask

    // T3: duty 64->200 requested at cnt=100; old duty finishes the period.
    task automatic test_mid_period_update();
        int hi1, hi2, ackn, ackpos, coinc_bad;
        prescale = 16'd0;
        load({24'd0, 8'd64}, 8'b0000_0010);
        enable = 1'b1;
        hi1 = 0; hi2 = 0; ackn = 0; ackpos = -1; coinc_bad = 0;
        for (int k = 1; k <= 510; k++) begin
            if (k == 101) begin
                duty_in = {24'd0, 8'd200}; mode_in = 8'b0000_0010; update_req = 1'b1;
            end
            step();
            update_req = 1'b0;
            if (led[0] === 1'b1) begin
                if (k <= 255) hi1++; else hi2++;
            end
            if (update_ack === 1'b1) begin
                ackn++; ackpos = k;
                if (period_tick !== 1'b1) coinc_bad++;
            end
        end
        total++; if (hi1 !== 64) $display("FAIL t3_old_high: got %0d expected 64", hi1); else passed++;
        total++; if (hi2 !== 200) $display("FAIL t3_new_high: got %0d expected 200", hi2); else passed++;
        total++; if (ackn !== 1) $display("FAIL t3_ack_count: got %0d expected 1", ackn); else passed++;
        total++; if (ackpos !== 255) $display("FAIL t3_ack_pos: got %0d expected 255", ackpos); else passed++;
        total++; if (coinc_bad !== 0) $display("FAIL t3_ack_tick: got %0d acks without tick expected 0", coinc_bad); else passed++;
    endtask

    // T4: blink duty 255, blink_half 1 -> on,on,off,off; request at the end of
    // period 4 (E1020) is held through period 5 and applied at its end.
    task automatic test_blink_and_late_update();
        int hi[6];
        int exp_hi[6];
        int ackn, ackpos;
        exp_hi = '{255, 255, 0, 0, 255, 10};
        prescale = 16'd0; blink_half = 8'd1;
        load({24'd0, 8'd255}, 8'b0000_0011);
        enable = 1'b1;
        for (int p = 0; p < 6; p++) hi[p] = 0;
        ackn = 0; ackpos = -1;
        for (int k = 1; k <= 1530; k++) begin
            if (k == 1020) begin
                duty_in = {24'd0, 8'd10}; mode_in = 8'b0000_0010; update_req = 1'b1;
            end
            step();
            update_req = 1'b0;
            if (led[0] === 1'b1) hi[(k - 1) / 255]++;
            if (update_ack === 1'b1) begin ackn++; ackpos = k; end
        end
        for (int p = 0; p < 6; p++) begin
            total++; if (hi[p] !== exp_hi[p]) $display("FAIL t4_high p%0d: got %0d expected %0d", p, hi[p], exp_hi[p]); else passed++;
        end
        total++; if (ackn !== 1) $display("FAIL t4_ack_count: got %0d expected 1", ackn); else passed++;
        total++; if (ackpos !== 1275) $display("FAIL t4_ack_pos: got %0d expected 1275", ackpos); else passed++;
    endtask

    // T5: active-low pins, enable drop, then reset with an update pending.
    task automatic test_active_low_enable_reset();
        int ackn, bad;
        prescale = 16'd0; blink_half = 8'd0;
        load(32'd0, 8'b0101_0101);
        enable = 1'b1;
        for (int j = 0; j < 20; j++) step();
        total++; if (led_al !== 4'b0000) $display("FAIL t5_on_al: got %b expected %b", led_al, 4'b0000); else passed++;
        total++; if (led !== 4'b1111) $display("FAIL t5_on: got %b expected %b", led, 4'b1111); else passed++;
        enable = 1'b0;
        step();
        total++; if (led_al !== 4'b1111) $display("FAIL t5_disable_al: got %b expected %b", led_al, 4'b1111); else passed++;
        total++; if (led !== 4'b0000) $display("FAIL t5_disable: got %b expected %b", led, 4'b0000); else passed++;
        enable = 1'b1;
        for (int j = 0; j < 40; j++) step();
        duty_in = 32'hFFFF_FFFF; mode_in = 8'b1010_1010; update_req = 1'b1;
        step();
        update_req = 1'b0;
        total++; if (update_ack !== 1'b0) $display("FAIL t5_ack_midperiod: got %b expected 0", update_ack); else passed++;
        rst_n = 1'b0;
        step();
        total++; if (update_ack_al !== 1'b0) $display("FAIL t5_ack_reset: got %b expected 0", update_ack_al); else passed++;
        total++; if (led_al !== 4'b1111) $display("FAIL t5_reset_al: got %b expected %b", led_al, 4'b1111); else passed++;
        total++; if (period_tick_al !== 1'b0) $display("FAIL t5_reset_tick: got %b expected 0", period_tick_al); else passed++;
        step();
        rst_n = 1'b1;
        ackn = 0; bad = 0;
        for (int j = 0; j < 300; j++) begin
            step();
            if (update_ack_al === 1'b1 || update_ack === 1'b1) ackn++;
            if (led_al !== 4'b1111) bad++;
        end
        total++; if (ackn !== 0) $display("FAIL t5_no_ack: got %0d acks expected 0", ackn); else passed++;
        total++; if (bad !== 0) $display("FAIL t5_led_after_reset: got %0d active samples expected 0", bad); else passed++;
    endtask

    initial begin
        test_reset();
        test_pwm_duty64();
        test_duty_extremes();
        test_mid_period_update();
        test_blink_and_late_update();
        test_active_low_enable_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
